// File: rtl/serial_subtractor_4_if.sv
// rtl/serial_subtractor_4_if.sv - start/done handshake and operand/result bundle for the bit-serial subtractor
interface serial_subtractor_4_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             busy;
  logic             done;

  modport master (
    output start, a, b, bin,
    input  diff, bout, busy, done
  );

  modport slave (
    input  start, a, b, bin,
    output diff, bout, busy, done
  );
endinterface

// File: rtl/serial_subtractor_4.sv
// rtl/serial_subtractor_4.sv - bit-serial a - b - bin, LSB first, one full-subtractor cell plus a borrow flop
module serial_subtractor_4 #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_subtractor_4_if.slave bus
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] ra_q, ra_d;
  logic [WIDTH-1:0] rb_q, rb_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             d_bit;
  logic             br_next;
  logic [WIDTH-1:0] res_next;

  always_comb begin
    state_d  = state_q;
    ra_d     = ra_q;
    rb_d     = rb_q;
    res_d    = res_q;
    diff_d   = diff_q;
    br_d     = br_q;
    bout_d   = bout_q;
    cnt_d    = cnt_q;
    d_bit    = ra_q[0] ^ rb_q[0] ^ br_q;
    br_next  = (~ra_q[0] & rb_q[0]) | (~(ra_q[0] ^ rb_q[0]) & br_q);
    res_next = {d_bit, res_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          ra_d    = bus.a;
          rb_d    = bus.b;
          br_d    = bus.bin;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        ra_d  = ra_q >> 1;
        rb_d  = rb_q >> 1;
        br_d  = br_next;
        res_d = res_next;
        cnt_d = cnt_q + CW'(1);
        // Visible result only updates once the last bit has been formed.
        if (cnt_q == CW'(WIDTH - 1)) begin
          diff_d  = res_next;
          bout_d  = br_next;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ra_q    <= '0;
      rb_q    <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ra_q    <= ra_d;
      rb_q    <= rb_d;
      res_q   <= res_d;
      diff_q  <= diff_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
  assign bus.busy = (state_q == SHIFT);
  assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_serial_subtractor_4.sv
// tb/tb_serial_subtractor_4.sv - randomized scoreboard bench for serial_subtractor_4
module tb_serial_subtractor_4;
  localparam int WIDTH = 4;

  typedef struct {
    logic [WIDTH-1:0] diff;
    logic             bout;
    int               acc;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   vectors;
  int   miscompares;
  exp_t sb[$];
  logic [WIDTH-1:0] last_diff;
  logic             last_bout;

  serial_subtractor_4_if #(.WIDTH(WIDTH)) bus ();

  serial_subtractor_4 #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("FAIL %s: actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Result is the arithmetic difference reduced mod 2^WIDTH; borrow is a plain comparison.
  function automatic exp_t model(input int a, input int b, input int bin, input int acc);
    exp_t e;
    int   r;
    r      = a - b - bin;
    e.diff = WIDTH'(((r % (1 << WIDTH)) + (1 << WIDTH)) % (1 << WIDTH));
    e.bout = (a < b + bin);
    e.acc  = acc;
    return e;
  endfunction

  // Monitor: busy during the WIDTH cycles after acceptance, done exactly WIDTH cycles after.
  always @(negedge clk) begin
    if (!rst) begin
      logic busy_exp;
      logic done_exp;
      busy_exp = 1'b0;
      done_exp = 1'b0;
      if (sb.size() > 0) begin
        busy_exp = (cyc >= sb[0].acc) && (cyc < sb[0].acc + WIDTH);
        done_exp = (cyc == sb[0].acc + WIDTH);
      end
      check("busy", int'(bus.busy), int'(busy_exp));
      check("done", int'(bus.done), int'(done_exp));
      if (done_exp) begin
        exp_t e;
        e = sb.pop_front();
        check("diff", int'(bus.diff), int'(e.diff));
        check("bout", int'(bus.bout), int'(e.bout));
        last_diff = e.diff;
        last_bout = e.bout;
      end else begin
        check("diff_hold", int'(bus.diff), int'(last_diff));
        check("bout_hold", int'(bus.bout), int'(last_bout));
      end
    end
  end

  // mode 0: start dropped, operands scrambled; 1: start held high; 2: start/operands randomized
  task automatic do_op(input int a, input int b, input int bin, input int mode);
    @(negedge clk);
    bus.a     = WIDTH'(a);
    bus.b     = WIDTH'(b);
    bus.bin   = bin[0];
    bus.start = 1'b1;
    sb.push_back(model(a, b, bin, cyc + 1));
    @(posedge clk);
    for (int i = 0; i <= WIDTH; i++) begin
      @(negedge clk);
      if (mode == 2 && i == 0) begin
        bus.a     = WIDTH'(1);
        bus.b     = WIDTH'(8);
        bus.start = 1'b1;
      end else begin
        bus.a   = WIDTH'($urandom);
        bus.b   = WIDTH'($urandom);
        bus.bin = 1'($urandom);
        if (mode == 0)      bus.start = 1'b0;
        else if (mode == 2) bus.start = 1'($urandom_range(0, 1));
      end
      @(posedge clk);
    end
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (n) @(posedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    last_diff   = '0;
    last_bout   = 1'b0;
    rst         = 1'b1;
    bus.start   = 1'b0;
    bus.a       = '0;
    bus.b       = '0;
    bus.bin     = 1'b0;
    #12;
    check("rst_diff", int'(bus.diff), 0);
    check("rst_bout", int'(bus.bout), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(2);

    do_op(9, 4, 0, 0);
    do_op(4, 9, 0, 0);
    do_op(0, 0, 1, 0);
    do_op(15, 15, 0, 0);
    do_op(7, 2, 0, 2);
    idle(5);

    // Abort an operation after two bits have been processed.
    @(negedge clk);
    bus.a     = WIDTH'(13);
    bus.b     = WIDTH'(6);
    bus.bin   = 1'b0;
    bus.start = 1'b1;
    sb.push_back(model(13, 6, 0, cyc + 1));
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b1;
    void'(sb.pop_back());
    last_diff = '0;
    last_bout = 1'b0;
    #1;
    check("abort_busy", int'(bus.busy), 0);
    check("abort_done", int'(bus.done), 0);
    check("abort_diff", int'(bus.diff), 0);
    check("abort_bout", int'(bus.bout), 0);
    @(negedge clk);
    rst = 1'b0;
    idle(3);
    do_op(12, 3, 1, 0);

    for (int a = 0; a < (1 << WIDTH); a++)
      for (int b = 0; b < (1 << WIDTH); b++)
        for (int c = 0; c < 2; c++)
          do_op(a, b, c, 1);

    for (int i = 0; i < 60; i++)
      do_op(int'($urandom_range(0, (1 << WIDTH) - 1)), int'($urandom_range(0, (1 << WIDTH) - 1)),
            int'($urandom_range(0, 1)), int'($urandom_range(0, 2)));

    idle(10);
    check("scoreboard_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
